// File: rtl/sys_pkg.sv
// sys_pkg: shared definitions for the systolic MAC array.
//   - MAX_W / default widths used by the PE and the array controller
//   - prod_width(): product width for a given operand width
//   - drain_cmd_e + drain_decode(): drain-chain command encoding, shared
//     with the array controller (load has priority over shift)
//   - sat_add(): accumulate step with optional signed saturation at acc_w
package sys_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ACC_W_DEF  = 40;
   // Widest accumulator sat_add can handle; operands are passed sign-extended to this width.
   localparam int unsigned MAX_W      = 64;

   typedef enum logic [1:0] {
      DRN_HOLD  = 2'd0,
      DRN_SHIFT = 2'd1,
      DRN_LOAD  = 2'd2
   } drain_cmd_e;

   function automatic int unsigned prod_width(input int unsigned data_w);
      return 2 * data_w;
   endfunction

   function automatic drain_cmd_e drain_decode(input logic ld, input logic sh);
      drain_cmd_e cmd;
      cmd = DRN_HOLD;
      if (ld)
         cmd = DRN_LOAD;
      else if (sh)
         cmd = DRN_SHIFT;
      return cmd;
   endfunction

   // a and b are acc_w-bit signed values sign-extended to MAX_W. The exact
   // sum is formed one bit wider, then either clamped to the acc_w signed
   // range or wrapped by re-sign-extending its low acc_w bits.
   function automatic logic signed [MAX_W-1:0] sat_add(
      input logic signed [MAX_W-1:0] a,
      input logic signed [MAX_W-1:0] b,
      input int unsigned             acc_w,
      input logic                    sat
   );
      logic signed [MAX_W:0] full;
      logic signed [MAX_W:0] hi;
      logic signed [MAX_W:0] lo;
      logic signed [MAX_W:0] wrap;
      logic signed [MAX_W:0] r;
      int unsigned           sh;
      full = (MAX_W+1)'(a) + (MAX_W+1)'(b);
      hi   = ((MAX_W+1)'(1) <<< (acc_w - 1)) - (MAX_W+1)'(1);
      lo   = -((MAX_W+1)'(1) <<< (acc_w - 1));
      sh   = MAX_W + 1 - acc_w;
      wrap = (full <<< sh) >>> sh;
      if (sat) begin
         if (full > hi)
            r = hi;
         else if (full < lo)
            r = lo;
         else
            r = full;
      end else begin
         r = wrap;
      end
      return MAX_W'(r);
   endfunction

endpackage

// File: rtl/sys_mac_pe_if.sv
// Link interfaces for the systolic PE.
//   sys_beat_if  : operand beat (w, f, vld, last) moving east/south
//   sys_drain_if : drain-chain link (psum, psum_v) moving south
// master drives the link, slave receives it.
interface sys_beat_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0] w;
   logic [DATA_W-1:0] f;
   logic              vld;
   logic              last;

   modport master (output w, output f, output vld, output last);
   modport slave  (input  w, input  f, input  vld, input  last);
endinterface

interface sys_drain_if #(
   parameter int unsigned ACC_W = 40
);
   logic [ACC_W-1:0] psum;
   logic             psum_v;

   modport master (output psum, output psum_v);
   modport slave  (input  psum, input  psum_v);
endinterface

// File: rtl/sys_mac_acc.sv
// sys_mac_acc: two-stage signed MAC with last-tagged vector boundaries.
//   Stage 1 registers the full-width product with its vld/last tags.
//   Stage 2 accumulates (saturating or wrapping); on a last beat the sum
//   goes to the held result, res_full is set and the accumulator clears.
// Ports:
//   clk, rst (async, active-high), en (global stall)
//   w, f, vld, last : operand beat
//   take            : drain chain is loading the held result this cycle
//   result          : held dot-product result
//   res_full        : result awaiting drain
//   ovf_err         : sticky, a result was overwritten before being drained
module sys_mac_acc
   import sys_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned SAT    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] w,
   input  logic signed [DATA_W-1:0] f,
   input  logic                     vld,
   input  logic                     last,
   input  logic                     take,
   output logic signed [ACC_W-1:0]  result,
   output logic                     res_full,
   output logic                     ovf_err
);

   localparam int unsigned PW = prod_width(DATA_W);

   logic signed [PW-1:0]    prod;
   logic                    p_vld;
   logic                    p_last;
   logic signed [ACC_W-1:0] acc;
   logic signed [MAX_W-1:0] acc_x;
   logic signed [MAX_W-1:0] prod_x;
   logic signed [ACC_W-1:0] sum;

   always_comb begin
      acc_x  = MAX_W'(acc);
      prod_x = MAX_W'(prod);
      sum    = ACC_W'(sat_add(acc_x, prod_x, ACC_W, SAT != 0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod     <= '0;
         p_vld    <= 1'b0;
         p_last   <= 1'b0;
         acc      <= '0;
         result   <= '0;
         res_full <= 1'b0;
         ovf_err  <= 1'b0;
      end else if (en) begin
         prod   <= w * f;
         p_vld  <= vld;
         p_last <= last;
         // A drain load empties the holder; a result landing in the same
         // cycle refills it below (later assignment wins).
         if (take)
            res_full <= 1'b0;
         if (p_vld) begin
            if (p_last) begin
               result   <= sum;
               res_full <= 1'b1;
               acc      <= '0;
               if (res_full && !take)
                  ovf_err <= 1'b1;
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: rtl/sys_mac_pe.sv
// sys_mac_pe: output-stationary systolic processing element.
//   Weights pass east and features pass south through one register stage;
//   the MAC core accumulates last-tagged vectors; the held result is
//   drained through a per-column shift chain so the next vector can
//   accumulate meanwhile.
// Ports:
//   clk, rst (async, active-high), en (0 freezes every register)
//   feed     : incoming beat (w_in, f_in, in_vld, in_last)
//   fwd      : registered beat to neighbours (w_out, f_out, out_vld, out_last)
//   chain_n  : drain chain from the PE above (psum_in, psum_in_v)
//   chain_s  : drain chain to the PE below (psum_out, psum_out_v)
//   drain_ld : load held result into the chain (wins over drain_sh)
//   drain_sh : shift the chain one stage
//   res_full : result awaiting drain
//   ovf_err  : sticky, a result was lost
module sys_mac_pe
   import sys_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned SAT    = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   sys_beat_if.slave    feed,
   sys_beat_if.master   fwd,
   sys_drain_if.slave   chain_n,
   sys_drain_if.master  chain_s,
   input  logic         drain_ld,
   input  logic         drain_sh,
   output logic         res_full,
   output logic         ovf_err
);

   logic [DATA_W-1:0]       w_q;
   logic [DATA_W-1:0]       f_q;
   logic                    vld_q;
   logic                    last_q;
   logic [ACC_W-1:0]        psum_q;
   logic                    psum_v_q;
   logic signed [ACC_W-1:0] result;
   drain_cmd_e              cmd;

   always_comb begin
      cmd = drain_decode(drain_ld, drain_sh);
   end

   sys_mac_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SAT    (SAT)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .w        (feed.w),
      .f        (feed.f),
      .vld      (feed.vld),
      .last     (feed.last),
      .take     (cmd == DRN_LOAD),
      .result   (result),
      .res_full (res_full),
      .ovf_err  (ovf_err)
   );

   // Operands forward every enabled cycle, valid or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q    <= '0;
         f_q    <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
      end else if (en) begin
         w_q    <= feed.w;
         f_q    <= feed.f;
         vld_q  <= feed.vld;
         last_q <= feed.last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psum_q   <= '0;
         psum_v_q <= 1'b0;
      end else if (en) begin
         unique case (cmd)
            DRN_LOAD: begin
               psum_q   <= result;
               psum_v_q <= res_full;
            end
            DRN_SHIFT: begin
               psum_q   <= chain_n.psum;
               psum_v_q <= chain_n.psum_v;
            end
            default: ;
         endcase
      end
   end

   assign fwd.w          = w_q;
   assign fwd.f          = f_q;
   assign fwd.vld        = vld_q;
   assign fwd.last       = last_q;
   assign chain_s.psum   = psum_q;
   assign chain_s.psum_v = psum_v_q;

endmodule

// File: tb/tb_sys_mac_pe.sv
// Directed bench for sys_mac_pe. Three PEs share one stimulus stream:
//   a: DATA_W=16 ACC_W=40 SAT=1, b: ACC_W=32 SAT=1, c: ACC_W=32 SAT=0.
module tb_sys_mac_pe;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] w;
   logic [15:0] f;
   logic        vld;
   logic        last;
   logic [39:0] pin;
   logic        pin_v;
   logic        dld;
   logic        dsh;
   logic        full_a, full_b, full_c;
   logic        ovf_a, ovf_b, ovf_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sys_beat_if  #(.DATA_W(16)) feed_a (), fwd_a (), feed_b (), fwd_b (), feed_c (), fwd_c ();
   sys_drain_if #(.ACC_W(40))  chn_a (), chs_a ();
   sys_drain_if #(.ACC_W(32))  chn_b (), chs_b (), chn_c (), chs_c ();

   assign feed_a.w = w;  assign feed_a.f = f;  assign feed_a.vld = vld;  assign feed_a.last = last;
   assign feed_b.w = w;  assign feed_b.f = f;  assign feed_b.vld = vld;  assign feed_b.last = last;
   assign feed_c.w = w;  assign feed_c.f = f;  assign feed_c.vld = vld;  assign feed_c.last = last;
   assign chn_a.psum = pin;        assign chn_a.psum_v = pin_v;
   assign chn_b.psum = pin[31:0];  assign chn_b.psum_v = pin_v;
   assign chn_c.psum = pin[31:0];  assign chn_c.psum_v = pin_v;

   sys_mac_pe #(.DATA_W(16), .ACC_W(40), .SAT(1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .feed(feed_a), .fwd(fwd_a), .chain_n(chn_a), .chain_s(chs_a),
      .drain_ld(dld), .drain_sh(dsh), .res_full(full_a), .ovf_err(ovf_a));
   sys_mac_pe #(.DATA_W(16), .ACC_W(32), .SAT(1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .feed(feed_b), .fwd(fwd_b), .chain_n(chn_b), .chain_s(chs_b),
      .drain_ld(dld), .drain_sh(dsh), .res_full(full_b), .ovf_err(ovf_b));
   sys_mac_pe #(.DATA_W(16), .ACC_W(32), .SAT(0)) dut_c (
      .clk(clk), .rst(rst), .en(en), .feed(feed_c), .fwd(fwd_c), .chain_n(chn_c), .chain_s(chs_c),
      .drain_ld(dld), .drain_sh(dsh), .res_full(full_c), .ovf_err(ovf_c));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] wv, input logic [15:0] fv, input logic lst);
      w = wv; f = fv; vld = 1'b1; last = lst;
      tick();
      vld = 1'b0; last = 1'b0;
   endtask

   task automatic idle();
      vld = 1'b0; last = 1'b0;
      tick();
   endtask

   task automatic drain();
      dld = 1'b1;
      idle();
      dld = 1'b0;
   endtask

   // Asynchronous pulse, released between clock edges.
   task automatic pulse_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, ".w_out"},    64'(fwd_a.w),      64'd0);
      check({tag, ".f_out"},    64'(fwd_a.f),      64'd0);
      check({tag, ".out_vld"},  64'(fwd_a.vld),    64'd0);
      check({tag, ".out_last"}, 64'(fwd_a.last),   64'd0);
      check({tag, ".psum"},     64'(chs_a.psum),   64'd0);
      check({tag, ".psum_v"},   64'(chs_a.psum_v), 64'd0);
      check({tag, ".res_full"}, 64'(full_a),       64'd0);
      check({tag, ".ovf_err"},  64'(ovf_a),        64'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; w = '0; f = '0; vld = 1'b0; last = 1'b0;
      pin = '0; pin_v = 1'b0; dld = 1'b0; dsh = 1'b0;
      #12;
      check_reset_a("rst0");
      rst = 1'b0;

      // Basic MAC: 1*5+2*6+3*7+4*8 = 70
      beat(16'd1, 16'd5, 1'b0);
      check("pass.w",    64'(fwd_a.w),   64'd1);
      check("pass.f",    64'(fwd_a.f),   64'd5);
      check("pass.vld",  64'(fwd_a.vld), 64'd1);
      beat(16'd2, 16'd6, 1'b0);
      beat(16'd3, 16'd7, 1'b0);
      beat(16'd4, 16'd8, 1'b1);
      check("pass.last", 64'(fwd_a.last), 64'd1);
      check("mac.full_early", 64'(full_a), 64'd0);
      idle();
      check("mac.full", 64'(full_a), 64'd1);
      check("pass.vld_idle", 64'(fwd_a.vld), 64'd0);
      drain();
      check("mac.psum",   64'(chs_a.psum),   64'd70);
      check("mac.psum_v", 64'(chs_a.psum_v), 64'd1);
      check("mac.full_clr", 64'(full_a), 64'd0);

      // Chain shift, load priority, hold
      pin = 40'h12345; pin_v = 1'b1; dsh = 1'b1;
      tick();
      check("sh.psum",   64'(chs_a.psum),   64'h12345);
      check("sh.psum_v", 64'(chs_a.psum_v), 64'd1);
      dld = 1'b1;
      tick();
      check("ldpri.psum",   64'(chs_a.psum),   64'd70);
      check("ldpri.psum_v", 64'(chs_a.psum_v), 64'd0);
      dld = 1'b0; dsh = 1'b0; pin = 40'h777;
      tick();
      check("hold.psum", 64'(chs_a.psum), 64'd70);
      pin = '0; pin_v = 1'b0;

      // Saturation: 3 x 0x7FFF*0x7FFF (0x3FFF0001)
      pulse_reset();
      beat(16'h7FFF, 16'h7FFF, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b1);
      idle();
      drain();
      check("satp.b", 64'(chs_b.psum), 64'h7FFF_FFFF);
      check("satp.c", 64'(chs_c.psum), 64'hBFFD_0003);
      check("satp.a", 64'(chs_a.psum), 64'h00_BFFD_0003);
      // Negative: 3 x (-32768*32767) = -0xBFFE8000
      beat(16'h8000, 16'h7FFF, 1'b0);
      beat(16'h8000, 16'h7FFF, 1'b0);
      beat(16'h8000, 16'h7FFF, 1'b1);
      idle();
      drain();
      check("satn.b", 64'(chs_b.psum), 64'h8000_0000);
      check("satn.c", 64'(chs_c.psum), 64'h4001_8000);
      check("satn.a", 64'(chs_a.psum), 64'hFF_4001_8000);

      // Back-to-back: A=6 single beat, B=16+1=17, drain_ld as B's last hits stage 2
      pulse_reset();
      beat(16'd2, 16'd3, 1'b1);
      beat(16'd4, 16'd4, 1'b0);
      beat(16'd1, 16'd1, 1'b1);
      drain();
      check("b2b.psum",   64'(chs_a.psum),   64'd6);
      check("b2b.psum_v", 64'(chs_a.psum_v), 64'd1);
      check("b2b.full",   64'(full_a),       64'd1);
      check("b2b.ovf",    64'(ovf_a),        64'd0);
      drain();
      check("b2b.held", 64'(chs_a.psum), 64'd17);

      // Overflow: two single-beat vectors, no drain in between
      pulse_reset();
      beat(16'd2, 16'd3, 1'b1);
      beat(16'd5, 16'd7, 1'b1);
      check("ovf.pre", 64'(ovf_a), 64'd0);
      idle();
      check("ovf.set", 64'(ovf_a), 64'd1);
      drain();
      check("ovf.psum", 64'(chs_a.psum), 64'd35);
      drain();
      check("ovf.empty_v", 64'(chs_a.psum_v), 64'd0);
      check("ovf.sticky",  64'(ovf_a),        64'd1);

      // Stall 3 cycles mid-vector with garbage on the inputs
      pulse_reset();
      beat(16'd1, 16'd5, 1'b0);
      beat(16'd2, 16'd6, 1'b0);
      en = 1'b0; w = 16'd99; f = 16'd99; vld = 1'b1; last = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         check("stall.w_out",    64'(fwd_a.w),    64'd2);
         check("stall.out_last", 64'(fwd_a.last), 64'd0);
      end
      check("stall.full", 64'(full_a), 64'd0);
      en = 1'b1;
      beat(16'd3, 16'd7, 1'b0);
      beat(16'd4, 16'd8, 1'b1);
      check("stall.full_early", 64'(full_a), 64'd0);
      idle();
      check("stall.full_set", 64'(full_a), 64'd1);
      drain();
      check("stall.psum", 64'(chs_a.psum), 64'd70);
      check("stall.ovf",  64'(ovf_a),      64'd0);

      // Reset mid-vector discards the partial sum
      beat(16'd100, 16'd100, 1'b0);
      beat(16'd100, 16'd100, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_a("rst_mid");
      #2;
      rst = 1'b0;
      beat(16'd3, 16'd3, 1'b1);
      idle();
      drain();
      check("rst_mid.psum", 64'(chs_a.psum), 64'd9);

      // Reset while a result is held
      beat(16'd7, 16'd7, 1'b1);
      idle();
      check("rst_full.pre", 64'(full_a), 64'd1);
      rst = 1'b1;
      #1;
      check_reset_a("rst_full");
      #2;
      rst = 1'b0;
      drain();
      check("rst_full.psum_v", 64'(chs_a.psum_v), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
